// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and types for the LoongArch32 instruction fetch stage
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP         = 32'h0340_0000;  // andi r0,r0,0

  typedef enum logic {
    RUN       = 1'b0,
    HALT_ADEF = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - ROM, redirect and decode-handshake bundle of the fetch stage
interface if_stage_if;

  logic        irom_en;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adef;

  modport master (
    output irom_en, irom_addr, id_valid, id_pc, id_inst, id_adef,
    input  irom_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  irom_en, irom_addr, id_valid, id_pc, id_inst, id_adef,
    output irom_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// rtl/if_stage_fetch_fifo.sv - fall-through {pc, inst, adef} FIFO between ROM response and decode
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic [2:0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush restarts the ring at slot 0; a push in the same cycle lands there.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (push) begin
        mem_d[0] = wr_data;
        wr_ptr_d = ptr_inc('0);
        count_d  = 3'd1;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == 3'(DEPTH));
  assign count   = count_q;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_q == 3'd0) && !flush));

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - LoongArch32 fetch stage: PC, ROM issue, redirect flush, decode FIFO
// Optional misaligned-redirect halt (adef entry) enabled by defining IF_ADEF_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         pending_q, pending_d;
  logic         drop_q, drop_d;
  fetch_state_t state_q, state_d;

  logic [2:0]   fifo_count;
  logic         fifo_full;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         push;
  logic         pop;
  logic         issue;
  logic         head_valid;
  logic [3:0]   occupancy;
  logic [3:0]   limit;
  logic [31:0]  redirect_target;
  logic         redirect_misaligned;

`ifdef IF_ADEF_EN
  assign redirect_target     = bus.redirect_pc;
  assign redirect_misaligned = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
`else
  logic unused_bits;
  assign redirect_target     = {bus.redirect_pc[31:2], 2'b00};
  assign redirect_misaligned = 1'b0;
  assign unused_bits         = ^{bus.redirect_pc[1:0], head.adef, redirect_misaligned};
`endif

  assign head_valid = (fifo_count != 3'd0) & ~rst;
  assign pop        = head_valid & bus.id_ready;

  // Entries held plus the one in flight must leave room after this cycle's pop.
  assign occupancy = {1'b0, fifo_count} + {3'b000, pending_q};
  assign limit     = 4'(DEPTH) + {3'b000, pop};
  assign issue     = ~rst & (state_q == RUN) & ~bus.redirect_valid & (occupancy < limit);

  always_comb begin
    push       = pending_q & ~drop_q & ~bus.redirect_valid;
    push_entry = '{pc: req_pc_q, inst: bus.irom_rdata, adef: 1'b0};
`ifdef IF_ADEF_EN
    if (redirect_misaligned) begin
      push       = 1'b1;
      push_entry = '{pc: bus.redirect_pc, inst: INST_NOP, adef: 1'b1};
    end
`endif
  end

  // With a one-cycle ROM the outstanding response always lands in the redirect
  // cycle itself and is discarded there, so drop never needs to outlive a cycle.
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    pending_d = 1'b0;
    drop_d    = 1'b0;
    state_d   = state_q;
    if (bus.redirect_valid) begin
      pc_d = redirect_target;
`ifdef IF_ADEF_EN
      state_d = redirect_misaligned ? HALT_ADEF : RUN;
`endif
    end else if (issue) begin
      pending_d = 1'b1;
      req_pc_d  = pc_q;
      pc_d      = next_pc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      state_q   <= RUN;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.irom_en   = issue;
  assign bus.irom_addr = pc_q;
  assign bus.id_valid  = head_valid;
  assign bus.id_pc     = head_valid ? head.pc   : 32'd0;
  assign bus.id_inst   = head_valid ? head.inst : 32'd0;
`ifdef IF_ADEF_EN
  assign bus.id_adef   = head_valid & head.adef;
`else
  assign bus.id_adef   = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !bus.redirect_valid));

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a fetch-stream model
module tb_if_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3 ^ (a * 32'd2654435761);
  endfunction

  // Synchronous ROM; unrequested cycles return noise so stale data is visible.
  always @(posedge clk) begin
    bus.irom_rdata <= bus.irom_en ? rom_word(bus.irom_addr) : $urandom;
  end

  // Model: entries sitting in the FIFO, one fetch possibly in flight, and the
  // in-order stream of PCs decode must receive.
  int          fifo_items;
  int          inflight;
  int          pops;
  logic        halted;
  logic        exp_adef;
  logic [31:0] fetch_pc;
  logic [31:0] exp_pc;
  logic [31:0] adef_pc;

  task automatic model_reset();
    fifo_items = 0;
    inflight   = 0;
    halted     = 1'b0;
    exp_adef   = 1'b0;
    fetch_pc   = RST_PC;
    exp_pc     = RST_PC;
    adef_pc    = '0;
  endtask

  task automatic do_reset(input int n);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    for (int i = 0; i < n; i++) begin
      #2;
      check("rst_irom_en",  bus.irom_en,  0);
      check("rst_id_valid", bus.id_valid, 0);
      check("rst_id_pc",    bus.id_pc,    0);
      check("rst_id_inst",  bus.id_inst,  0);
      check("rst_id_adef",  bus.id_adef,  0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic ready, input logic redir, input logic [31:0] tgt);
    logic exp_valid;
    logic pop;
    logic exp_en;
    bus.id_ready       = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    #2;
    exp_valid = (fifo_items > 0);
    pop       = exp_valid & ready;
    exp_en    = !redir && !halted && ((fifo_items + inflight - int'(pop)) < DEPTH);
    check("id_valid", bus.id_valid, exp_valid);
    check("irom_en",  bus.irom_en,  exp_en);
    if (exp_en) check("irom_addr", bus.irom_addr, fetch_pc);
    if (pop) begin
      pops++;
      if (exp_adef) begin
        check("adef_pc",   bus.id_pc,   adef_pc);
        check("adef_inst", bus.id_inst, 32'h0340_0000);
        check("adef_flag", bus.id_adef, 1);
        exp_adef = 1'b0;
      end else begin
        check("id_pc",   bus.id_pc,   exp_pc);
        check("id_inst", bus.id_inst, rom_word(exp_pc));
        check("id_adef", bus.id_adef, 0);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (redir) begin
      fifo_items = 0;
      inflight   = 0;
      exp_adef   = 1'b0;
`ifdef IF_ADEF_EN
      if (tgt[1:0] != 2'b00) begin
        halted     = 1'b1;
        fifo_items = 1;
        exp_adef   = 1'b1;
        adef_pc    = tgt;
      end else begin
        halted   = 1'b0;
        fetch_pc = tgt;
        exp_pc   = tgt;
      end
`else
      fetch_pc = {tgt[31:2], 2'b00};
      exp_pc   = fetch_pc;
`endif
    end else begin
      fifo_items = fifo_items + inflight - int'(pop);
      inflight   = exp_en ? 1 : 0;
      if (exp_en) fetch_pc = fetch_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input logic ready);
    for (int i = 0; i < n; i++) cycle(ready, 1'b0, '0);
  endtask

  int          r;
  logic        rdy;
  logic [31:0] tgt;

  initial begin
    rst                = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    pops               = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    // startup latency and full-rate streaming
    run(8, 1'b1);
    // stall until full, then drain without gaps
    run(6, 1'b0);
    check("stall_irom_en", bus.irom_en, 0);
    run(8, 1'b1);
    // redirect coinciding with a pop and a ROM response
    cycle(1'b1, 1'b1, 32'h1c00_0100);
    run(6, 1'b1);
    // redirect with the FIFO full
    run(4, 1'b0);
    cycle(1'b0, 1'b1, 32'h1c00_0100);
    run(6, 1'b1);
    // back-to-back redirects: last one wins
    cycle(1'b1, 1'b1, 32'h1c00_0300);
    cycle(1'b1, 1'b1, 32'h1c00_0400);
    run(6, 1'b1);
    // reset pulse with FIFO full and a fetch pending
    run(2, 1'b0);
    do_reset(1);
    run(6, 1'b1);
    // PC wrap-around
    cycle(1'b1, 1'b1, 32'hffff_fffc);
    run(5, 1'b1);
    // misaligned redirect, then aligned recovery
    cycle(1'b1, 1'b1, 32'h1c00_0102);
    run(6, 1'b1);
    cycle(1'b1, 1'b1, 32'h1c00_0200);
    run(6, 1'b1);

    for (int c = 0; c < 1500; c++) begin
      r   = int'($urandom_range(0, 199));
      rdy = ($urandom_range(0, 3) != 0);
      tgt = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2)
            + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      if (r == 0) do_reset(1);
      else cycle(rdy, (r < 10), tgt);
    end
    check("progress", (pops >= 300), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the LoongArch32 five-stage pipeline. It owns the PC and issues sequential reads to a synchronous instruction ROM.
- Fetched {pc, inst} pairs are buffered in a small FIFO and presented to the decode stage (CTRL/regfile) over a valid/ready handshake.
- Taken branches and jumps resolved in EX redirect the stage. A redirect flushes the FIFO and any in-flight fetch.

Parameters:
- RESET_PC, 32'h1c00_0000, PC of the first fetch after reset.
- DEPTH, 2, FIFO entries; legal values 2..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- irom_en  out  1  ROM read request. Combinational from state and FIFO occupancy.
- irom_addr  out  32  ROM byte address (word aligned). Combinational, equal to pc_q.
- irom_rdata  in  32  ROM data; valid the cycle after the matching irom_en.
- redirect_valid  in  1  EX taken branch/jump.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  FIFO head is valid.
- id_ready  in  1  decode accepts; low on hazard stall.
- id_pc  out  32  PC of FIFO head.
- id_inst  out  32  instruction at FIFO head.
- id_adef  out  1  head carries an address-error flag (only with the optional feature; otherwise tied 0).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - pc_q = RESET_PC, FIFO empty, pending = 0, drop = 0, state = RUN.
  - id_valid = 0, id_pc = 0, id_inst = 0, id_adef = 0, irom_en = 0 while rst is high.
- pop = id_valid & id_ready.
- Issue condition: issue = (state == RUN) & !redirect_valid & (count + pending - pop < DEPTH).
  - irom_en = issue; irom_addr = pc_q.
  - On issue: pending <= 1, req_pc <= pc_q, pc_q <= pc_q + 4. Wrap-around is modulo 2^32.
- Response cycle: when pending = 1, irom_rdata is valid.
  - If drop = 0 and there is no redirect this cycle, push {req_pc, irom_rdata} into the FIFO.
  - pending clears unless a new issue occurs in the same cycle.
- Latency: first fetch is issued in the first cycle with rst low. id_valid rises 2 cycles later.
- Throughput: with id_ready held high, 1 instruction per cycle.
- FIFO:
  - Push and pop may occur in the same cycle; count is unchanged.
  - Push is never attempted when the FIFO is full; the issue rule guarantees this. An assertion checks it.
  - id_* are driven from registered FIFO storage, not from irom_rdata.
- Redirect has highest priority, above push, pop and issue:
  - FIFO count <= 0.
  - Any response arriving in the redirect cycle is discarded.
  - pc_q <= redirect_pc.
  - No issue occurs in the redirect cycle.
  - id_valid is 0 in the next cycle; the fetch of redirect_pc is issued in the next cycle.
  - A pop in the redirect cycle still completes. Decode owns that handshake; EX squashes younger work.
- drop flag: set on redirect while an issue from the previous cycle is outstanding, so that stale response is discarded. In the DEPTH-bounded design, pending clears on redirect, and the response in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins.
- rst mid-operation: next cycle matches the reset state exactly, regardless of FIFO or pending contents.
- States: RUN (normal fetch) and HALT_ADEF (exists only with the optional feature).

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 moves to HALT_ADEF and issues nothing.
  - One FIFO entry {redirect_pc, INST_NOP} is pushed with its adef bit set. id_adef = 1 while it is at the head.
  - The stage stays in HALT_ADEF until the next aligned redirect or rst.
- Undefined:
  - redirect_pc[1:0] is forced to 0. There is no HALT_ADEF state, and id_adef is tied to 0.

Decomposition:
- Package if_pkg:
  - RESET_PC_DEFAULT = 32'h1c00_0000.
  - INST_NOP = 32'h0340_0000 (andi r0,r0,0).
  - fetch_state_t enum {RUN, HALT_ADEF}.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0], adef}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, fall-through head.
  - Signals: push, pop, flush, full, count.
  - if_stage instantiates it once.

Test Plan:
- Reset release, id_ready = 1 → irom_addr = 1c000000, 1c000004, 1c000008 on successive cycles; id_valid first high 2 cycles after rst falls with id_pc = 1c000000; then one instruction per cycle in order.
- id_ready = 0 for 6 cycles after startup → count reaches DEPTH and irom_en drops. On release, id_pc continues 1c000000, 1c000004, 1c000008 … with no gaps or duplicates.
- Redirect with FIFO full and a fetch in flight, redirect_pc = 1c000100 → next cycle id_valid = 0 and irom_addr = 1c000100. Next valid id_pc = 1c000100; no stale PC below 1c000100 appears.
- Redirect coinciding with a pop and a ROM response → the popped entry is delivered once, the response is discarded, and the next id_pc equals the target.
- rst pulsed for 1 cycle with FIFO full and pending set → next cycle id_valid = 0. The first fetch after release is at RESET_PC.
- redirect_pc = 1c000102:
  - With IF_ADEF_EN: one entry appears with id_pc = 1c000102, id_inst = 03400000, id_adef = 1. irom_en stays 0 until a redirect to 1c000200, which resumes fetch.
  - Without IF_ADEF_EN: fetch resumes at 1c000100.
